// File: rtl/control_unit.sv
// Microcoded sequencer for the SAP-1.5 CPU: microstep counter plus halted bit,
// with a combinational control word decoded from step, opcode and flags.
module control_unit #(
    parameter int unsigned STEP_WIDTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       flag_carry,
    input  logic       flag_zero,
    output logic       pc_enable,
    output logic       pc_load,
    output logic       pc_oe,
    output logic       mar_load,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_oe,
    output logic       a_load,
    output logic       a_oe,
    output logic       b_load,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halt
);

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic [STEP_WIDTH-1:0] {StT0, StT1, StT2, StT3, StT4} step_e;

    typedef struct packed {
        logic pc_enable;
        logic pc_load;
        logic pc_oe;
        logic mar_load;
        logic ram_oe;
        logic ram_we;
        logic ir_load;
        logic ir_oe;
        logic a_load;
        logic a_oe;
        logic b_load;
        logic alu_oe;
        logic alu_sub;
        logic flags_load;
        logic out_load;
        logic halt;
    } ctrl_t;

    step_e step_q, step_d;
    logic  halted_q, halted_d;
    ctrl_t cw;
    ctrl_t cw_out;

    // State register: microstep and halted bit, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= StT0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Microcode decode: next step, halted bit and control word.
    always_comb begin
        cw       = '0;
        step_d   = step_q;
        halted_d = halted_q;
        if (halted_q) begin
            cw.halt = 1'b1;
            step_d  = StT0;
        end else begin
            case (step_q)
                StT0: begin
                    // run only matters here; a started instruction always completes
                    if (run) begin
                        cw.pc_oe    = 1'b1;
                        cw.mar_load = 1'b1;
                        step_d      = StT1;
                    end
                end
                StT1: begin
                    cw.ram_oe    = 1'b1;
                    cw.ir_load   = 1'b1;
                    cw.pc_enable = 1'b1;
                    step_d       = StT2;
                end
                StT2: begin
                    step_d = StT0;
                    case (opcode)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            cw.ir_oe    = 1'b1;
                            cw.mar_load = 1'b1;
                            step_d      = StT3;
                        end
                        OpLdi: begin
                            cw.ir_oe  = 1'b1;
                            cw.a_load = 1'b1;
                        end
                        OpJmp: begin
                            cw.ir_oe   = 1'b1;
                            cw.pc_load = 1'b1;
                        end
                        OpJc: begin
                            cw.ir_oe   = flag_carry;
                            cw.pc_load = flag_carry;
                        end
                        OpJz: begin
                            cw.ir_oe   = flag_zero;
                            cw.pc_load = flag_zero;
                        end
                        OpOut: begin
                            cw.a_oe     = 1'b1;
                            cw.out_load = 1'b1;
                        end
                        OpHlt: halted_d = 1'b1;
                        default: ;
                    endcase
                end
                StT3: begin
                    step_d = StT0;
                    case (opcode)
                        OpLda: begin
                            cw.ram_oe = 1'b1;
                            cw.a_load = 1'b1;
                        end
                        OpAdd, OpSub: begin
                            cw.ram_oe = 1'b1;
                            cw.b_load = 1'b1;
                            step_d    = StT4;
                        end
                        OpSta: begin
                            cw.a_oe   = 1'b1;
                            cw.ram_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT4: begin
                    step_d = StT0;
                    if (opcode == OpAdd || opcode == OpSub) begin
                        cw.alu_oe     = 1'b1;
                        cw.a_load     = 1'b1;
                        cw.flags_load = 1'b1;
                        cw.alu_sub    = (opcode == OpSub);
                    end
                end
                default: step_d = StT0;
            endcase
        end
    end

    // Reset silences the whole control word, including mid-instruction writes.
    always_comb begin
        cw_out = reset ? '0 : cw;
    end

    assign pc_enable  = cw_out.pc_enable;
    assign pc_load    = cw_out.pc_load;
    assign pc_oe      = cw_out.pc_oe;
    assign mar_load   = cw_out.mar_load;
    assign ram_oe     = cw_out.ram_oe;
    assign ram_we     = cw_out.ram_we;
    assign ir_load    = cw_out.ir_load;
    assign ir_oe      = cw_out.ir_oe;
    assign a_load     = cw_out.a_load;
    assign a_oe       = cw_out.a_oe;
    assign b_load     = cw_out.b_load;
    assign alu_oe     = cw_out.alu_oe;
    assign alu_sub    = cw_out.alu_sub;
    assign flags_load = cw_out.flags_load;
    assign out_load   = cw_out.out_load;
    assign halt       = cw_out.halt;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed per-cycle vector table, halt timing
// sequence and a random-opcode run checking bus/PC invariants and step timing.
module tb_control_unit;

    localparam logic [15:0] PC_EN  = 16'h8000;
    localparam logic [15:0] PC_LD  = 16'h4000;
    localparam logic [15:0] PC_OE  = 16'h2000;
    localparam logic [15:0] MAR_LD = 16'h1000;
    localparam logic [15:0] RAM_OE = 16'h0800;
    localparam logic [15:0] RAM_WE = 16'h0400;
    localparam logic [15:0] IR_LD  = 16'h0200;
    localparam logic [15:0] IR_OE  = 16'h0100;
    localparam logic [15:0] A_LD   = 16'h0080;
    localparam logic [15:0] A_OE   = 16'h0040;
    localparam logic [15:0] B_LD   = 16'h0020;
    localparam logic [15:0] ALU_OE = 16'h0010;
    localparam logic [15:0] ALU_SB = 16'h0008;
    localparam logic [15:0] FLG_LD = 16'h0004;
    localparam logic [15:0] OUT_LD = 16'h0002;
    localparam logic [15:0] HALT   = 16'h0001;
    localparam logic [15:0] F0     = PC_OE | MAR_LD;
    localparam logic [15:0] F1     = RAM_OE | IR_LD | PC_EN;
    localparam logic [15:0] NONE   = 16'h0000;

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset, run, flag_carry, flag_zero;
    logic [3:0] opcode;
    logic pc_enable, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt;
    logic [15:0] act_cw;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    control_unit #(.STEP_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .flag_carry(flag_carry), .flag_zero(flag_zero),
        .pc_enable(pc_enable), .pc_load(pc_load), .pc_oe(pc_oe), .mar_load(mar_load),
        .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load), .ir_oe(ir_oe),
        .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe),
        .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load), .halt(halt)
    );

    assign act_cw = {pc_enable, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe,
                     a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt};

    task automatic add(input logic r, input logic rn, input logic [3:0] op,
                       input logic c, input logic z, input logic [15:0] e);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op; v.c = c; v.z = z; v.exp = e;
        vecs.push_back(v);
    endtask

    // Three-cycle instruction: fetch T0, T1, then the given T2 word.
    task automatic add3(input logic [3:0] op, input logic c, input logic z,
                        input logic [15:0] t2);
        add(1'b0, 1'b1, op, c, z, F0);
        add(1'b0, 1'b1, op, c, z, F1);
        add(1'b0, 1'b1, op, c, z, t2);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_invariants(input string name);
        int n_oe;
        n_oe = int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe);
        checks++;
        if (n_oe > 1 || (pc_load && pc_enable)) begin
            errors++;
            $display("FAIL %s invariant: oe_count %0d pc_load %b pc_enable %b",
                     name, n_oe, pc_load, pc_enable);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run = 1'b1;
    endtask

    initial begin
        int halt_cycle;
        int m;
        int len;
        logic [3:0] rop;

        reset = 1'b1; run = 1'b0; opcode = 4'h0; flag_carry = 1'b0; flag_zero = 1'b0;

        // ---- directed vector table, one entry per clock cycle ----
        add(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, NONE);
        add3(4'h5, 1'b0, 1'b0, IR_OE | A_LD);                  // LDI
        add3(4'hE, 1'b0, 1'b0, A_OE | OUT_LD);                 // OUT
        add3(4'h2, 1'b1, 1'b1, IR_OE | MAR_LD);                // ADD T0..T2
        add(1'b0, 1'b1, 4'h2, 1'b1, 1'b1, RAM_OE | B_LD);
        add(1'b0, 1'b1, 4'h2, 1'b1, 1'b1, ALU_OE | A_LD | FLG_LD);
        add3(4'h3, 1'b0, 1'b0, IR_OE | MAR_LD);                // SUB
        add(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, RAM_OE | B_LD);
        add(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, ALU_OE | A_LD | FLG_LD | ALU_SB);
        add3(4'h1, 1'b0, 1'b0, IR_OE | MAR_LD);                // LDA, run drops in T3
        add(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, RAM_OE | A_LD);
        add(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, NONE);
        add(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, NONE);
        add3(4'h7, 1'b0, 1'b1, NONE);                          // JC not taken
        add3(4'h7, 1'b1, 1'b0, IR_OE | PC_LD);                 // JC taken
        add3(4'h8, 1'b1, 1'b0, NONE);                          // JZ not taken
        add3(4'h8, 1'b0, 1'b1, IR_OE | PC_LD);                 // JZ taken
        add3(4'h4, 1'b0, 1'b0, IR_OE | MAR_LD);                // STA, reset in T3
        add(1'b1, 1'b1, 4'h4, 1'b0, 1'b0, NONE);
        add3(4'h9, 1'b1, 1'b1, NONE);                          // undefined = NOP
        add3(4'hD, 1'b0, 1'b0, NONE);
        add3(4'h6, 1'b0, 1'b0, IR_OE | PC_LD);                 // JMP
        add3(4'h0, 1'b0, 1'b0, NONE);                          // NOP
        add3(4'h4, 1'b0, 1'b0, IR_OE | MAR_LD);                // STA full
        add(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, A_OE | RAM_WE);
        add3(4'hF, 1'b0, 1'b0, NONE);                          // HLT
        add(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, HALT);
        add(1'b0, 1'b0, 4'h5, 1'b1, 1'b1, HALT);
        add(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, HALT);
        add(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, NONE);
        add(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, F0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            run = vecs[i].run;
            opcode = vecs[i].op;
            flag_carry = vecs[i].c;
            flag_zero = vecs[i].z;
            #1;
            check($sformatf("vec[%0d]", i), act_cw, vecs[i].exp);
        end

        // ---- LDI, OUT, HLT from reset: halt on cycle 10, then held ----
        do_reset();
        halt_cycle = 0;
        for (int n = 1; n <= 30 && halt_cycle == 0; n++) begin
            if (n > 1) @(negedge clk);
            opcode = (n <= 3) ? 4'h5 : (n <= 6) ? 4'hE : 4'hF;
            #1;
            if (halt) halt_cycle = n;
        end
        checks++;
        if (halt_cycle != 10) begin
            errors++;
            $display("FAIL halt_cycle: got %0d expected 10", halt_cycle);
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            run = n[0];
            #1;
            check($sformatf("halt_hold[%0d]", n), act_cw, HALT);
        end

        // ---- random opcodes: invariants and instruction length ----
        do_reset();
        m = 0;
        len = 3;
        rop = 4'h0;
        for (int k = 0; k < 10000; k++) begin
            if (k > 0) @(negedge clk);
            if (m == 0) begin
                rop = 4'($urandom_range(0, 14));
                len = (rop == 4'h1 || rop == 4'h4) ? 4 : (rop == 4'h2 || rop == 4'h3) ? 5 : 3;
            end
            opcode = rop;
            flag_carry = 1'($urandom_range(0, 1));
            flag_zero = 1'($urandom_range(0, 1));
            #1;
            check_invariants("rand");
            check("rand_fetch", {15'd0, pc_oe & mar_load}, {15'd0, m == 0});
            if (m == 2 && rop >= 4'h9 && rop <= 4'hD) check("rand_undef_t2", act_cw, NONE);
            m = (m + 1 == len) ? 0 : m + 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
